// File: rtl/execute_mem_refill_ctrl.sv
// Memory-stage backing-port sequencer: arbitrates store drains against load-miss
// refills and uncached loads on one bus port, and drives the dcache tag/data
// update interface for line refills (invalidate, fill words, validate).
module execute_mem_refill_ctrl #(
    parameter int unsigned LINE_WORDS   = 4,
    parameter int unsigned WB_BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bco_valid,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_uncached,
    output logic        refill_done,
    output logic [31:0] refill_data,
    input  logic        wbmem_valid,
    input  logic [31:0] wbmem_addr,
    input  logic [3:0]  wbmem_strb,
    input  logic [31:0] wbmem_data,
    input  logic        wbmem_uncached,
    output logic        wbmem_en,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic        mem_req_burst,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_strb,
    output logic [31:0] mem_req_data,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_last,
    input  logic        mem_wack,
    output logic        update_tag_en,
    output logic [31:0] update_tag_addr,
    output logic        update_tag_valid,
    output logic        update_data_valid,
    output logic [31:0] update_data_addr,
    output logic [3:0]  update_data_strb,
    output logic [31:0] update_data,
    input  logic        update_data_ready,
    output logic        err
);

    localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W  = $clog2(WB_BURST_MAX + 1);
    localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WB_BURST_MAX);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] WB_REQ   = 4'd1;
    localparam logic [3:0] WB_ACK   = 4'd2;
    localparam logic [3:0] WB_POP   = 4'd3;
    localparam logic [3:0] RF_INVAL = 4'd4;
    localparam logic [3:0] RF_REQ   = 4'd5;
    localparam logic [3:0] RF_DATA  = 4'd6;
    localparam logic [3:0] RF_TAG   = 4'd7;
    localparam logic [3:0] UC_REQ   = 4'd8;
    localparam logic [3:0] UC_DATA  = 4'd9;
    localparam logic [3:0] DONE     = 4'd10;

    logic [3:0]        state, state_d;
    logic [CNT_W-1:0]  wb_cnt;
    logic [BEAT_W-1:0] beat;
    logic              killed;
    logic [31:0]       addr_q;
    logic [31:0]       line_base;

    logic wb_go, accept, rsp_xfer, last_beat, uc_xfer;

    // Stores are drained through the same path regardless of cacheability.
    logic unused_wbmem_uncached;
    assign unused_wbmem_uncached = wbmem_uncached;

    // Stores win unless a miss has already waited through WB_BURST_MAX drains.
    assign wb_go     = wbmem_valid && (!req_valid || (wb_cnt < CNT_MAX));
    assign accept    = (state == IDLE) && !wb_go && req_valid;
    assign rsp_xfer  = (state == RF_DATA) && mem_rsp_valid && update_data_ready;
    assign last_beat = (beat == LAST_BEAT);
    assign uc_xfer   = (state == UC_DATA) && mem_rsp_valid;

    // Next-state sequencing.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (wb_go)       state_d = WB_REQ;
                else if (accept) state_d = req_uncached ? UC_REQ : RF_INVAL;
            end
            WB_REQ:   if (mem_req_ready) state_d = WB_ACK;
            WB_ACK:   if (mem_wack) state_d = WB_POP;
            WB_POP:   state_d = IDLE;
            RF_INVAL: state_d = RF_REQ;
            RF_REQ:   if (mem_req_ready) state_d = RF_DATA;
            RF_DATA:  if (rsp_xfer && last_beat) state_d = RF_TAG;
            RF_TAG:   state_d = DONE;
            UC_REQ:   if (mem_req_ready) state_d = UC_DATA;
            UC_DATA:  if (mem_rsp_valid) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, counters, latched request and captured read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wb_cnt      <= '0;
            beat        <= '0;
            killed      <= 1'b0;
            err         <= 1'b0;
            addr_q      <= '0;
            line_base   <= '0;
            refill_data <= '0;
        end else begin
            state <= state_d;

            if (!req_valid || accept) wb_cnt <= '0;
            else if (state == WB_POP) wb_cnt <= wb_cnt + CNT_W'(1);

            if (accept) begin
                addr_q    <= req_addr;
                line_base <= req_addr & ~LINE_MASK;
                killed    <= 1'b0;
            end else if (bco_valid && (state != IDLE)) begin
                // Flush only hides completion; the fill itself still runs to the end.
                killed <= 1'b1;
            end

            if ((state == RF_REQ) && mem_req_ready) beat <= '0;
            else if (rsp_xfer) beat <= beat + BEAT_W'(1);

            if ((rsp_xfer && (beat == addr_q[BEAT_W+1:2])) || uc_xfer) begin
                refill_data <= mem_rsp_data;
            end

            // Beat counter drives sequencing; a wrong last flag is only reported.
            if (rsp_xfer && (mem_rsp_last != last_beat)) err <= 1'b1;
        end
    end

    // Output decode from registered state.
    always_comb begin
        req_ready         = accept;
        refill_done       = 1'b0;
        wbmem_en          = 1'b0;
        mem_req_valid     = 1'b0;
        mem_req_write     = 1'b0;
        mem_req_burst     = 1'b0;
        mem_req_addr      = '0;
        mem_req_strb      = '0;
        mem_req_data      = '0;
        mem_rsp_ready     = 1'b0;
        update_tag_en     = 1'b0;
        update_tag_addr   = '0;
        update_tag_valid  = 1'b0;
        update_data_valid = 1'b0;
        update_data_addr  = '0;
        update_data_strb  = '0;
        update_data       = '0;
        case (state)
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = wbmem_addr;
                mem_req_strb  = wbmem_strb;
                mem_req_data  = wbmem_data;
            end
            WB_POP: wbmem_en = 1'b1;
            RF_INVAL: begin
                update_tag_en   = 1'b1;
                update_tag_addr = line_base;
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_burst = 1'b1;
                mem_req_addr  = line_base;
            end
            RF_DATA: begin
                update_data_valid = mem_rsp_valid;
                update_data_addr  = line_base | 32'({beat, 2'b00});
                update_data_strb  = 4'hf;
                update_data       = mem_rsp_data;
                mem_rsp_ready     = update_data_ready;
            end
            RF_TAG: begin
                update_tag_en    = 1'b1;
                update_tag_addr  = line_base;
                update_tag_valid = 1'b1;
            end
            UC_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
            end
            UC_DATA: mem_rsp_ready = 1'b1;
            DONE:    refill_done = ~killed;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_execute_mem_refill_ctrl.sv
// Directed bench for execute_mem_refill_ctrl: refills, stalls, flush, uncached
// loads, store-drain arbitration and the rsp_last protocol error.
module tb_execute_mem_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bco_valid, req_valid, req_ready, req_uncached, refill_done;
    logic [31:0] req_addr, refill_data;
    logic        wbmem_valid, wbmem_uncached, wbmem_en;
    logic [31:0] wbmem_addr, wbmem_data;
    logic [3:0]  wbmem_strb;
    logic        mem_req_valid, mem_req_ready, mem_req_write, mem_req_burst;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [3:0]  mem_req_strb;
    logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_last, mem_wack;
    logic [31:0] mem_rsp_data;
    logic        update_tag_en, update_tag_valid, update_data_valid, update_data_ready;
    logic [31:0] update_tag_addr, update_data_addr, update_data;
    logic [3:0]  update_data_strb;
    logic        err;

    int tests  = 0;
    int failed = 0;

    execute_mem_refill_ctrl #(.LINE_WORDS(4), .WB_BURST_MAX(4)) dut (
        .clk(clk), .reset(reset), .bco_valid(bco_valid),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_uncached(req_uncached), .refill_done(refill_done), .refill_data(refill_data),
        .wbmem_valid(wbmem_valid), .wbmem_addr(wbmem_addr), .wbmem_strb(wbmem_strb),
        .wbmem_data(wbmem_data), .wbmem_uncached(wbmem_uncached), .wbmem_en(wbmem_en),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_burst(mem_req_burst),
        .mem_req_addr(mem_req_addr), .mem_req_strb(mem_req_strb), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last), .mem_wack(mem_wack),
        .update_tag_en(update_tag_en), .update_tag_addr(update_tag_addr),
        .update_tag_valid(update_tag_valid), .update_data_valid(update_data_valid),
        .update_data_addr(update_data_addr), .update_data_strb(update_data_strb),
        .update_data(update_data), .update_data_ready(update_data_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        bco_valid = 0; req_valid = 0; req_addr = '0; req_uncached = 0;
        wbmem_valid = 0; wbmem_addr = '0; wbmem_strb = '0; wbmem_data = '0;
        wbmem_uncached = 0; mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
        mem_rsp_last = 0; mem_wack = 0; update_data_ready = 1;
    endtask

    task automatic do_reset;
        reset = 1;
        clear_inputs();
        cyc(); cyc();
        reset = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_done"}, refill_done, 1'b0);
        chk1({tag, "_memreq"}, mem_req_valid, 1'b0);
        chk1({tag, "_rspready"}, mem_rsp_ready, 1'b0);
        chk1({tag, "_tagen"}, update_tag_en, 1'b0);
        chk1({tag, "_dvalid"}, update_data_valid, 1'b0);
        chk1({tag, "_wben"}, wbmem_en, 1'b0);
    endtask

    // Cacheable refill of the line holding addr; bus word i = dbase + i.
    // Optional 3-cycle update_data_ready stall before beat stall_beat, bco pulse
    // on beat flush_beat, and mem_rsp_last raised on beat last_at.
    task automatic refill(input string tag, input logic [31:0] addr, input logic [31:0] dbase,
                          input int stall_beat, input int flush_beat, input int last_at,
                          input logic exp_done);
        logic [31:0] base;
        base = addr & 32'hffff_fff0;
        cyc(); req_valid = 1; req_addr = addr; req_uncached = 0;
        #1 chk1({tag, "_accept"}, req_ready, 1'b1);
        cyc(); req_valid = 0;
        #1 chk1({tag, "_inval_en"}, update_tag_en, 1'b1);
        chk1({tag, "_inval_v"}, update_tag_valid, 1'b0);
        chk32({tag, "_inval_addr"}, update_tag_addr, base);
        cyc();
        #1 chk1({tag, "_req_v"}, mem_req_valid, 1'b1);
        chk1({tag, "_req_burst"}, mem_req_burst, 1'b1);
        chk1({tag, "_req_wr"}, mem_req_write, 1'b0);
        chk32({tag, "_req_addr"}, mem_req_addr, base);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_beat) begin
                for (int s = 0; s < 3; s++) begin
                    cyc(); update_data_ready = 0; mem_rsp_valid = 1;
                    mem_rsp_data = dbase + 32'(i); mem_rsp_last = (i == last_at);
                    #1 chk1({tag, "_stall_rdy"}, mem_rsp_ready, 1'b0);
                    chk1({tag, "_stall_dv"}, update_data_valid, 1'b1);
                    chk32({tag, "_stall_addr"}, update_data_addr, base + 32'(4 * i));
                    chk32({tag, "_stall_data"}, update_data, dbase + 32'(i));
                end
            end
            cyc(); update_data_ready = 1; mem_rsp_valid = 1;
            mem_rsp_data = dbase + 32'(i); mem_rsp_last = (i == last_at);
            bco_valid = (i == flush_beat);
            #1 chk1({tag, "_dv"}, update_data_valid, 1'b1);
            chk1({tag, "_rdy"}, mem_rsp_ready, 1'b1);
            chk32({tag, "_daddr"}, update_data_addr, base + 32'(4 * i));
            chk32({tag, "_data"}, update_data, dbase + 32'(i));
            chk32({tag, "_strb"}, {28'b0, update_data_strb}, 32'hf);
        end
        cyc(); mem_rsp_valid = 0; mem_rsp_last = 0; bco_valid = 0;
        #1 chk1({tag, "_val_en"}, update_tag_en, 1'b1);
        chk1({tag, "_val_v"}, update_tag_valid, 1'b1);
        chk32({tag, "_val_addr"}, update_tag_addr, base);
        chk1({tag, "_early_done"}, refill_done, 1'b0);
        cyc();
        #1 chk1({tag, "_done"}, refill_done, exp_done);
        chk32({tag, "_rdata"}, refill_data, dbase + 32'(addr[3:2]));
        cyc();
        #1 chk1({tag, "_done_clr"}, refill_done, 1'b0);
    endtask

    int remaining, pops, pops_at_accept, pops_at_done, rbeat;
    logic accepted;

    initial begin
        do_reset();
        #1 chk_quiet("rst");
        chk1("rst_req_ready", req_ready, 1'b0);
        chk32("rst_rdata", refill_data, 32'h0);
        chk1("rst_err", err, 1'b0);

        // Basic refill: done 8 cycles after accept, word 2 returned.
        refill("rf", 32'h0000_1008, 32'hA000_0000, -1, -1, 3, 1'b1);
        chk1("rf_err", err, 1'b0);

        // Stall mid-burst before beat 1; requested word is beat 1.
        refill("stall", 32'h0000_2004, 32'hB000_0000, 1, -1, 3, 1'b1);

        // Flush during the fill: line completes, completion is hidden.
        refill("flush", 32'h0000_300C, 32'hC000_0000, -1, 1, 3, 1'b0);

        // Uncached load.
        cyc(); req_valid = 1; req_addr = 32'hBFC0_0004; req_uncached = 1;
        #1 chk1("uc_accept", req_ready, 1'b1);
        cyc(); req_valid = 0; req_uncached = 0;
        #1 chk1("uc_req_v", mem_req_valid, 1'b1);
        chk1("uc_req_burst", mem_req_burst, 1'b0);
        chk32("uc_req_addr", mem_req_addr, 32'hBFC0_0004);
        chk1("uc_tag", update_tag_en, 1'b0);
        cyc(); mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
        #1 chk1("uc_rsp_rdy", mem_rsp_ready, 1'b1);
        chk1("uc_no_dupd", update_data_valid, 1'b0);
        cyc(); mem_rsp_valid = 0;
        #1 chk1("uc_done", refill_done, 1'b1);
        chk32("uc_rdata", refill_data, 32'hDEAD_BEEF);
        chk1("uc_no_tag", update_tag_en, 1'b0);

        // mem_rsp_last on beat 1: sticky error, fill still completes.
        refill("last", 32'h0000_4000, 32'hD000_0000, -1, -1, 1, 1'b1);
        chk1("last_err", err, 1'b1);
        cyc(); #1 chk1("last_err_sticky", err, 1'b1);
        do_reset();
        #1 chk1("last_err_rst", err, 1'b0);
        chk32("last_rdata_rst", refill_data, 32'h0);

        // Reset during RF_DATA: quiet next cycle even with a beat on the bus.
        cyc(); req_valid = 1; req_addr = 32'h0000_6000;
        cyc(); req_valid = 0;
        cyc();
        cyc(); mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
        #1 chk1("mid_dv", update_data_valid, 1'b1);
        reset = 1;
        cyc();
        #1 chk_quiet("mid_rst");
        reset = 0; clear_inputs();

        // Arbitration: 6 stores and a held miss -> 4 drains, miss, 2 drains.
        remaining = 6; pops = 0; pops_at_accept = -1; pops_at_done = -1; rbeat = 0;
        accepted = 0;
        mem_wack = 1; mem_rsp_valid = 1;
        for (int c = 0; c < 80; c++) begin
            cyc();
            wbmem_valid = (remaining > 0);
            wbmem_addr  = 32'h0000_0100 + 32'(4 * (6 - remaining));
            wbmem_data  = 32'h5500_0000 + 32'(6 - remaining);
            wbmem_strb  = 4'hf;
            req_valid   = !accepted; req_addr = 32'h0000_5000;
            mem_rsp_last = (rbeat == 3);
            mem_rsp_data = 32'(rbeat);
            #1;
            if (mem_req_valid && mem_req_write) begin
                chk32("wb_addr", mem_req_addr, wbmem_addr);
                chk32("wb_data", mem_req_data, wbmem_data);
            end
            if (wbmem_en && remaining > 0) begin
                pops++; remaining--;
            end
            if (req_ready) begin
                accepted = 1; pops_at_accept = pops;
            end
            if (mem_rsp_valid && mem_rsp_ready) rbeat++;
            if (refill_done) pops_at_done = pops;
        end
        chk32("arb_pops_before_miss", 32'(pops_at_accept), 32'd4);
        chk32("arb_pops_at_done", 32'(pops_at_done), 32'd4);
        chk32("arb_total_pops", 32'(pops), 32'd6);
        chk32("arb_beats", 32'(rbeat), 32'd4);
        chk1("arb_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
